// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the uTPU host UART (transmitter and receiver).
//   - tx_state_e   : transmitter FSM states
//   - IDLE_LEVEL   : line level when nothing is being sent
//   - START_LEVEL  : line level of the start bit
//   - UART_BITS_DEFAULT : default data bits per frame, common to TX and RX
//   - even_parity16 : even-parity helper (XOR of all bits)
// Optional feature macro used by the transmitter: UART_TX_PARITY_EN.
package uart_pkg;

  localparam int UART_BITS_DEFAULT = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Words narrower than 16 bits are zero-extended by the caller; extra
  // zeros leave the parity unchanged.
  function automatic logic even_parity16(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if
// Word handshake plus serial output of the UART transmitter.
//   valid : word offered (master -> slave)
//   data  : word to send, W bits (master -> slave)
//   ready : transmitter idle and able to accept (slave -> master)
//   tx    : serial line, idle high (slave -> master)
//   busy  : frame in progress (slave -> master)
// Modports: master (word source), slave (transmitter).
interface uart_transmitter_if
  import uart_pkg::*;
#(
  parameter int W = UART_BITS_DEFAULT
) ();

  logic         valid;
  logic [W-1:0] data;
  logic         ready;
  logic         tx;
  logic         busy;

  modport master (
    output valid,
    output data,
    input  ready,
    input  tx,
    input  busy
  );

  modport slave (
    input  valid,
    input  data,
    output ready,
    output tx,
    output busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period with bit_done. While clear is high the count is held at
// zero so the first period after clear drops is a full one.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   clear    : hold counter at zero (no bit_done while high)
//   bit_done : high during the final cycle of a bit period
// Shared between the transmitter and the receiver.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Bit-period counter, wraps at the bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign bit_done = !clear && (cnt_r == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter
// 8N1-style UART transmitter: accepts a word on a valid/ready handshake and
// sends start bit, data LSB first, optional even parity, then stop bit(s).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (abandons any frame in flight)
//   bus   : uart_transmitter_if.slave (valid, data, ready, tx, busy)
// Parameters: UART_BITS_TRANSFERED (1..16), CLKS_PER_BIT (>=1),
//             STOP_BITS (1 or 2).
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the
// data bits and the stop bit(s).
// tx is registered from the next-state decode, so the line shows the new
// state's level in the first cycle of that state.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int UART_BITS_TRANSFERED = UART_BITS_DEFAULT,
  parameter int CLKS_PER_BIT         = 1,
  parameter int STOP_BITS            = 1
) (
  input logic               clk,
  input logic               rst_n,
  uart_transmitter_if.slave bus
);

  localparam int N   = UART_BITS_TRANSFERED;
  localparam int BCW = $clog2(N + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(N - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e      state_r, state_next_s;
  logic [N-1:0]   shift_r, shift_next_s;
  logic [BCW-1:0] bit_cnt_r, bit_cnt_next_s;
  logic           stop_cnt_r, stop_cnt_next_s;
  logic           tx_r, tx_next_s;
  logic           baud_clear_s;
  logic           bit_done_s;
`ifdef UART_TX_PARITY_EN
  logic           parity_r, parity_next_s;
`endif

  // Baud timer is held in IDLE so START always gets a full bit period.
  assign baud_clear_s = (state_r == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (baud_clear_s),
    .bit_done (bit_done_s)
  );

  // State, datapath and serial-line registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= {N{1'b0}};
      bit_cnt_r  <= {BCW{1'b0}};
      stop_cnt_r <= 1'b0;
      tx_r       <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_next_s;
      shift_r    <= shift_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      stop_cnt_r <= stop_cnt_next_s;
      tx_r       <= tx_next_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_next_s;
`endif
    end
  end

  // Next-state decode; tx_next_s is the level of the state being entered.
  always_comb begin
    state_next_s    = state_r;
    shift_next_s    = shift_r;
    bit_cnt_next_s  = bit_cnt_r;
    stop_cnt_next_s = stop_cnt_r;
    tx_next_s       = tx_r;
`ifdef UART_TX_PARITY_EN
    parity_next_s   = parity_r;
`endif
    case (state_r)
      IDLE: begin
        tx_next_s = IDLE_LEVEL;
        if (bus.valid) begin
          state_next_s    = START;
          shift_next_s    = bus.data;
          bit_cnt_next_s  = {BCW{1'b0}};
          stop_cnt_next_s = 1'b0;
          tx_next_s       = START_LEVEL;
`ifdef UART_TX_PARITY_EN
          parity_next_s   = even_parity16(16'(bus.data));
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_next_s = DATA;
          tx_next_s    = shift_r[0];
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          shift_next_s   = shift_r >> 1;
          bit_cnt_next_s = bit_cnt_r + BCW'(1);
          if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next_s = PARITY;
            tx_next_s    = parity_r;
`else
            state_next_s    = STOP;
            stop_cnt_next_s = 1'b0;
            tx_next_s       = IDLE_LEVEL;
`endif
          end else begin
            // Next data bit is the new LSB after the shift.
            tx_next_s = shift_next_s[0];
          end
        end else begin
          state_next_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done_s) begin
          state_next_s    = STOP;
          stop_cnt_next_s = 1'b0;
          tx_next_s       = IDLE_LEVEL;
        end else begin
          state_next_s = PARITY;
        end
      end
`endif
      STOP: begin
        tx_next_s = IDLE_LEVEL;
        if (bit_done_s) begin
          if (stop_cnt_r == LAST_STOP) begin
            state_next_s = IDLE;
          end else begin
            stop_cnt_next_s = stop_cnt_r + 1'b1;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
        tx_next_s    = IDLE_LEVEL;
      end
    endcase
  end

  assign bus.tx    = tx_r;
  assign bus.ready = (state_r == IDLE);
  assign bus.busy  = (state_r != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
// Directed bench for uart_transmitter: a default instance (8 bits, 1 clk
// per bit, 1 stop bit) and a CLKS_PER_BIT=4 instance. Expected frames are
// hand-written time-ordered bit strings (left = first bit on the line).
// Honours UART_TX_PARITY_EN when the design is built with it.
module tb_uart_transmitter;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  uart_transmitter_if #(.W(8)) bus  ();
  uart_transmitter_if #(.W(8)) bus4 ();

  uart_transmitter #(
    .UART_BITS_TRANSFERED(8), .CLKS_PER_BIT(1), .STOP_BITS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  uart_transmitter #(
    .UART_BITS_TRANSFERED(8), .CLKS_PER_BIT(4), .STOP_BITS(1)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;   // start, d0..d7, stop in time order (bit 9 first)
    logic       par;   // even parity of data
    string      name;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input int k, input logic [9:0] seq, input logic par);
    if (k < 9) return seq[9-k];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return par;
`endif
    return seq[0];
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready_wait"}, bus.ready, 1'b1);
  endtask

  // Samples FL cycles starting with the cycle after the handshake edge.
  task automatic check_frame(input logic [9:0] seq, input logic par, input string nm,
                             input bit chg, input logic [7:0] newd);
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      chk($sformatf("%s_tx%0d", nm, k), bus.tx, exp_bit(k, seq, par));
      chk($sformatf("%s_rdy%0d", nm, k), bus.ready, 1'b0);
      chk($sformatf("%s_busy%0d", nm, k), bus.busy, 1'b1);
      if (chg && k == 2) bus.data = newd;
    end
  endtask

  task automatic send_single(input logic [7:0] d, input logic [9:0] seq, input logic par,
                             input string nm);
    wait_ready(nm);
    bus.valid = 1'b1;
    bus.data  = d;
    check_frame(seq, par, nm, 1'b0, 8'h00);
    bus.valid = 1'b0;
    @(negedge clk);
    chk({nm, "_end_ready"}, bus.ready, 1'b1);
    chk({nm, "_end_tx"}, bus.tx, 1'b1);
    chk({nm, "_end_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    bus.valid  = 1'b0;
    bus.data   = 8'h00;
    bus4.valid = 1'b0;
    bus4.data  = 8'h00;

    tbl[0] = '{data: 8'hA5, seq: 10'b0101001011, par: 1'b0, name: "a5"};
    tbl[1] = '{data: 8'h07, seq: 10'b0111000001, par: 1'b1, name: "x07"};
    tbl[2] = '{data: 8'h3C, seq: 10'b0001111001, par: 1'b0, name: "x3c"};
    tbl[3] = '{data: 8'h80, seq: 10'b0000000011, par: 1'b1, name: "x80"};

    // Reset and idle line.
    repeat (5) @(negedge clk);
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst4_tx", bus4.tx, 1'b1);
    chk("rst4_ready", bus4.ready, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_tx%0d", i), bus.tx, 1'b1);
    end
    chk("idle_ready", bus.ready, 1'b1);
    chk("idle_busy", bus.busy, 1'b0);

    // Table-driven single frames.
    for (int v = 0; v < 4; v++) begin
      send_single(tbl[v].data, tbl[v].seq, tbl[v].par, tbl[v].name);
    end

    // Back-to-back with valid held: 0x01 then 0xFF, data changed mid-frame.
    wait_ready("b2b");
    bus.valid = 1'b1;
    bus.data  = 8'h01;
    check_frame(10'b0100000001, 1'b1, "b2b1", 1'b1, 8'hFF);
    @(negedge clk);
    chk("b2b_gap_tx", bus.tx, 1'b1);
    chk("b2b_gap_ready", bus.ready, 1'b1);
    check_frame(10'b0111111111, 1'b0, "b2b2", 1'b0, 8'h00);
    bus.valid = 1'b0;
    @(negedge clk);
    chk("b2b_end_ready", bus.ready, 1'b1);

    // Reset during data bit 3 of 0x00.
    wait_ready("mid");
    bus.valid = 1'b1;
    bus.data  = 8'h00;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_bit3_tx", bus.tx, 1'b0);
    chk("mid_bit3_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", bus.tx, 1'b1);
    chk("mid_rst_ready", bus.ready, 1'b1);
    chk("mid_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_tx", bus.tx, 1'b1);
    send_single(8'h81, 10'b0100000011, 1'b0, "x81");

    // Baud stretch: 0x3C with 4 clocks per bit.
    bus4.valid = 1'b1;
    bus4.data  = 8'h3C;
    for (int k = 0; k < FL; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0) bus4.valid = 1'b0;
        chk($sformatf("b4_tx%0d_%0d", k, c), bus4.tx, exp_bit(k, 10'b0001111001, 1'b0));
        chk($sformatf("b4_rdy%0d_%0d", k, c), bus4.ready, 1'b0);
      end
    end
    @(negedge clk);
    chk("b4_end_ready", bus4.ready, 1'b1);
    chk("b4_end_tx", bus4.tx, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
